// File: rtl/star_softmax_norm_if.sv
// Handshake and LUT bus of the softmax normalisation stage.
// The slave modport is the normaliser; the master modport is its surroundings
// (match-vector engine upstream, exp LUT, result consumer).
interface star_softmax_norm_if #(
  parameter int N_ELEM = 16,
  parameter int N_BKT  = 64,
  parameter int CNT_W  = 5,
  parameter int EXP_W  = 8,
  parameter int OUT_W  = 8
);
  localparam int AW = $clog2(N_BKT);
  localparam int IW = $clog2(N_ELEM);

  logic                   in_valid;
  logic                   in_ready;
  logic [N_BKT-1:0]       in_sub_mv;
  logic [N_BKT*CNT_W-1:0] in_sum_mv;
  logic                   lut_req;
  logic [AW-1:0]          lut_addr;
  logic [EXP_W-1:0]       lut_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic [IW-1:0]          out_idx;
  logic                   out_last;
  logic                   err_zero_den;
  logic                   done;

  modport slave (
    input  in_valid, in_sub_mv, in_sum_mv, lut_data, out_ready,
    output in_ready, lut_req, lut_addr, out_valid, out_data, out_idx,
           out_last, err_zero_den, done
  );

  modport master (
    output in_valid, in_sub_mv, in_sum_mv, lut_data, out_ready,
    input  in_ready, lut_req, lut_addr, out_valid, out_data, out_idx,
           out_last, err_zero_den, done
  );
endinterface

// File: rtl/star_softmax_norm.sv
// Softmax normalisation stage behind the STAR match-vector engine.
// Collects one row of one-hot bucket vectors plus the bucket histogram,
// accumulates the denominator sum(count[k]*exp[k]) from the exp LUT, then
// emits exp[bucket_j]*2^OUT_W/denom per element using a bit-serial
// restoring divider that saturates at 2^OUT_W-1.
module star_softmax_norm #(
  parameter int N_ELEM = 16,
  parameter int N_BKT  = 64,
  parameter int CNT_W  = 5,
  parameter int EXP_W  = 8,
  parameter int DEN_W  = 12,
  parameter int OUT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  star_softmax_norm_if.slave     bus
);
  localparam int AW  = $clog2(N_BKT);
  localparam int IW  = $clog2(N_ELEM);
  localparam int PW  = CNT_W + EXP_W;
  localparam int DCW = $clog2(OUT_W + 2);

  typedef enum logic [2:0] {
    IDLE, COLLECT, ACCUM, LREAD, LWAIT, DIV, OUT
  } state_t;

  state_t                 state;
  logic [N_BKT*CNT_W-1:0] sum_q;
  logic [AW-1:0]          bkt_q [N_ELEM];
  logic [N_ELEM-1:0]      null_q;
  logic [IW-1:0]          beat_cnt;
  logic [AW:0]            acc_cnt;
  logic [DEN_W-1:0]       denom;
  logic [IW-1:0]          elem;
  logic [DEN_W:0]         rem;
  logic [OUT_W:0]         quo;
  logic [DCW-1:0]         dcnt;

  logic                   in_ready_q;
  logic                   lut_req_q;
  logic [AW-1:0]          lut_addr_q;
  logic                   out_valid_q;
  logic [OUT_W-1:0]       out_data_q;
  logic [IW-1:0]          out_idx_q;
  logic                   out_last_q;
  logic                   err_q;
  logic                   done_q;

  logic                   beat_fire;
  logic [CNT_W-1:0]       cnt_arr [N_BKT];
  logic [AW-1:0]          acc_idx;
  logic [PW-1:0]          prod;
  logic [EXP_W-1:0]       numer;
  logic [DEN_W:0]         div_trial;
  logic                   div_ge;
  logic [DEN_W:0]         div_rem_nxt;
  logic [OUT_W:0]         quo_nxt;
  logic [IW-1:0]          elem_nxt;

  // Bucket of an element: lowest set bit wins, so multi-hot vectors collapse
  // to their smallest bucket index.
  function automatic logic [AW-1:0] lsb_index(input logic [N_BKT-1:0] v);
    lsb_index = '0;
    for (int k = N_BKT - 1; k >= 0; k--) begin
      if (v[k]) lsb_index = AW'(k);
    end
  endfunction

  // A set integer quotient bit means exp >= denom, i.e. probability >= 1.0,
  // which is clamped to the largest representable fraction.
  function automatic logic [OUT_W-1:0] sat_quo(input logic [OUT_W:0] q);
    sat_quo = q[OUT_W] ? {OUT_W{1'b1}} : q[OUT_W-1:0];
  endfunction

  assign bus.in_ready     = in_ready_q;
  assign bus.lut_req      = lut_req_q;
  assign bus.lut_addr     = lut_addr_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_last     = out_last_q;
  assign bus.err_zero_den = err_q;
  assign bus.done         = done_q;

  // Histogram unpacking, denominator term, and one restoring-divider step.
  always_comb begin
    beat_fire = bus.in_valid && in_ready_q;
    for (int k = 0; k < N_BKT; k++) begin
      cnt_arr[k] = sum_q[k*CNT_W +: CNT_W];
    end
    // LUT data lags its address by one cycle, so it belongs to bucket acc_cnt-1.
    acc_idx  = acc_cnt[AW-1:0] - 1'b1;
    prod     = {{EXP_W{1'b0}}, cnt_arr[acc_idx]} * {{CNT_W{1'b0}}, bus.lut_data};
    numer    = null_q[elem] ? '0 : bus.lut_data;
    elem_nxt = elem + 1'b1;
    // First step yields the integer bit from the unshifted numerator; the
    // remaining OUT_W steps shift in zeros for the fraction bits.
    div_trial   = (dcnt == '0) ? rem : {rem[DEN_W-1:0], 1'b0};
    div_ge      = div_trial >= {1'b0, denom};
    div_rem_nxt = div_ge ? (div_trial - {1'b0, denom}) : div_trial;
    quo_nxt     = {quo[OUT_W-1:0], div_ge};
  end

  // Frame controller: collection, denominator build, per-element divide/output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sum_q       <= '0;
      for (int i = 0; i < N_ELEM; i++) bkt_q[i] <= '0;
      null_q      <= '0;
      beat_cnt    <= '0;
      acc_cnt     <= '0;
      denom       <= '0;
      elem        <= '0;
      rem         <= '0;
      quo         <= '0;
      dcnt        <= '0;
      in_ready_q  <= 1'b0;
      lut_req_q   <= 1'b0;
      lut_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (beat_fire) begin
            sum_q     <= bus.in_sum_mv;
            bkt_q[0]  <= lsb_index(bus.in_sub_mv);
            null_q[0] <= ~|bus.in_sub_mv;
            beat_cnt  <= IW'(1);
            denom     <= '0;
            err_q     <= 1'b0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat_fire) begin
            bkt_q[beat_cnt]  <= lsb_index(bus.in_sub_mv);
            null_q[beat_cnt] <= ~|bus.in_sub_mv;
            if (beat_cnt == IW'(N_ELEM - 1)) begin
              in_ready_q <= 1'b0;
              acc_cnt    <= '0;
              lut_req_q  <= 1'b1;
              lut_addr_q <= '0;
              state      <= ACCUM;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ACCUM: begin
          if (acc_cnt != '0) denom <= denom + prod[DEN_W-1:0];
          if (acc_cnt == (AW+1)'(N_BKT)) begin
            elem       <= '0;
            lut_req_q  <= 1'b1;
            lut_addr_q <= bkt_q[0];
            state      <= LREAD;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == (AW+1)'(N_BKT - 1)) begin
              lut_req_q  <= 1'b0;
              lut_addr_q <= '0;
            end else begin
              lut_addr_q <= acc_cnt[AW-1:0] + 1'b1;
            end
          end
        end
        LREAD: begin
          lut_req_q  <= 1'b0;
          lut_addr_q <= '0;
          state      <= LWAIT;
        end
        LWAIT: begin
          if (denom == '0) begin
            err_q       <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b1;
            out_idx_q   <= elem;
            out_last_q  <= (elem == IW'(N_ELEM - 1));
            state       <= OUT;
          end else begin
            rem   <= {{(DEN_W + 1 - EXP_W){1'b0}}, numer};
            quo   <= '0;
            dcnt  <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          if (dcnt == DCW'(OUT_W + 1)) begin
            out_data_q  <= sat_quo(quo);
            out_valid_q <= 1'b1;
            out_idx_q   <= elem;
            out_last_q  <= (elem == IW'(N_ELEM - 1));
            state       <= OUT;
          end else begin
            rem  <= div_rem_nxt;
            quo  <= quo_nxt;
            dcnt <= dcnt + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (elem == IW'(N_ELEM - 1)) begin
              done_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state      <= IDLE;
            end else begin
              elem       <= elem_nxt;
              lut_req_q  <= 1'b1;
              lut_addr_q <= bkt_q[elem_nxt];
              state      <= LREAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_star_softmax_norm.sv
// Directed bench for star_softmax_norm: table of single-bucket frames with
// hand-computed probabilities, plus hand-written frames for multi-hot/null
// vectors with an output stall, and an asynchronous reset in mid-divide.
module tb_star_softmax_norm;
  localparam int N_ELEM = 16;
  localparam int N_BKT  = 64;
  localparam int CNT_W  = 5;
  localparam int EXP_W  = 8;
  localparam int DEN_W  = 12;
  localparam int OUT_W  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  star_softmax_norm_if #(.N_ELEM(N_ELEM), .N_BKT(N_BKT), .CNT_W(CNT_W),
                         .EXP_W(EXP_W), .OUT_W(OUT_W)) bus ();

  star_softmax_norm #(.N_ELEM(N_ELEM), .N_BKT(N_BKT), .CNT_W(CNT_W),
                      .EXP_W(EXP_W), .DEN_W(DEN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Exp LUT model: one-cycle read latency.
  logic [7:0] lut_mem [64];
  always @(posedge clk) bus.lut_data <= bus.lut_req ? lut_mem[bus.lut_addr] : 8'h00;

  int cyc = 0;
  int lut_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.lut_req) lut_cnt <= lut_cnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0]  fr_mv  [16];
  logic [319:0] fr_sum;
  logic [7:0]   fr_exp [16];
  logic         fr_err;

  typedef struct packed {
    logic [5:0] b0;   // bucket of element 0
    logic [5:0] br;   // bucket of elements 1..15
    logic [7:0] l0;   // lut[b0]
    logic [7:0] lr;   // lut[br]
    logic [7:0] e0;   // expected out_data idx 0
    logic [7:0] er;   // expected out_data idx 1..15
    logic       err;  // expected err_zero_den
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  task automatic pack_sum(input int cnt [64]);
    fr_sum = '0;
    for (int k = 0; k < 64; k++) fr_sum[k*5 +: 5] = 5'(cnt[k]);
  endtask

  task automatic build_vec(input vec_t v);
    int cnt [64];
    for (int k = 0; k < 64; k++) begin
      lut_mem[k] = 8'h00;
      cnt[k] = 0;
    end
    lut_mem[v.br] = v.lr;
    lut_mem[v.b0] = v.l0;
    for (int i = 0; i < 16; i++) begin
      fr_mv[i]  = 64'd1 << ((i == 0) ? v.b0 : v.br);
      fr_exp[i] = (i == 0) ? v.e0 : v.er;
    end
    cnt[v.b0] += 1;
    cnt[v.br] += 15;
    pack_sum(cnt);
    fr_err = v.err;
  endtask

  task automatic send_frame(output int t_last);
    int t;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_sub_mv = fr_mv[i];
      bus.in_sum_mv = fr_sum;
      t = 0;
      while (!bus.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!bus.in_ready) timeout_fail("in_ready");
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_sub_mv = '0;
    t_last = cyc;
  endtask

  task automatic recv_frame(input int n_res, input int stall_idx, input int t_last,
                            input bit chk_lat);
    int t;
    int t_hs;
    logic [7:0] hold_d;
    logic [3:0] hold_i;
    t_hs = t_last;
    for (int k = 0; k < n_res; k++) begin
      t = 0;
      @(negedge clk);
      while (!bus.out_valid && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!bus.out_valid) begin
        timeout_fail("out_valid");
        return;
      end
      if (chk_lat && k < 2) chk((k == 0) ? "first_latency" : "next_latency",
                                cyc - t_hs, (k == 0) ? 77 : 12);
      chk($sformatf("out_data[%0d]", k), bus.out_data, fr_exp[k]);
      chk($sformatf("out_idx[%0d]", k), bus.out_idx, k);
      chk($sformatf("out_last[%0d]", k), bus.out_last, (k == 15) ? 1 : 0);
      chk($sformatf("err_zero_den[%0d]", k), bus.err_zero_den, fr_err);
      if (k == stall_idx) begin
        hold_d = bus.out_data;
        hold_i = bus.out_idx;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, hold_d);
          chk("stall_idx", bus.out_idx, hold_i);
          chk("stall_lut_req", bus.lut_req, 0);
        end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      t_hs = cyc;
      if (k == 15) begin
        @(negedge clk);
        chk("done_pulse", bus.done, 1);
        @(negedge clk);
        chk("done_clear", bus.done, 0);
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, bus.in_ready, 0);
    chk({nm, "_lut_req"}, bus.lut_req, 0);
    chk({nm, "_lut_addr"}, bus.lut_addr, 0);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_out_data"}, bus.out_data, 0);
    chk({nm, "_out_idx"}, bus.out_idx, 0);
    chk({nm, "_out_last"}, bus.out_last, 0);
    chk({nm, "_err"}, bus.err_zero_den, 0);
    chk({nm, "_done"}, bus.done, 0);
  endtask

  initial begin
    int t_last;
    int lut_base;
    int cnt [64];

    //        b0     br     l0      lr      e0      er      err
    tbl[0] = '{6'd0, 6'd0,  8'd255, 8'd255, 8'd16,  8'd16,  1'b0}; // denom 4080
    tbl[1] = '{6'd0, 6'd63, 8'd255, 8'd0,   8'd255, 8'd0,   1'b0}; // denom 255, 256 saturates
    tbl[2] = '{6'd0, 6'd0,  8'd0,   8'd0,   8'd0,   8'd0,   1'b1}; // zero denominator
    tbl[3] = '{6'd1, 6'd2,  8'd100, 8'd50,  8'd30,  8'd15,  1'b0}; // denom 850
    tbl[4] = '{6'd5, 6'd5,  8'd10,  8'd10,  8'd16,  8'd16,  1'b0}; // denom 160

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sub_mv = '0;
    bus.in_sum_mv = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 64; k++) lut_mem[k] = 8'h00;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);

    for (int r = 0; r < 5; r++) begin
      build_vec(tbl[r]);
      lut_base = lut_cnt;
      send_frame(t_last);
      recv_frame(16, -1, t_last, r == 0);
      chk($sformatf("lut_reads_row%0d", r), lut_cnt - lut_base, 80);
    end

    // Multi-hot element 2 (bucket 1), null element 5, stall on idx 3.
    // counts: bucket0=14, bucket1=1; lut[0]=10, lut[1]=20 -> denom 160.
    for (int k = 0; k < 64; k++) begin
      lut_mem[k] = 8'h00;
      cnt[k] = 0;
    end
    lut_mem[0] = 8'd10;
    lut_mem[1] = 8'd20;
    cnt[0] = 14;
    cnt[1] = 1;
    pack_sum(cnt);
    for (int i = 0; i < 16; i++) begin
      fr_mv[i]  = 64'd1;
      fr_exp[i] = 8'd16;
    end
    fr_mv[2]  = 64'h0000_0000_0000_0006;
    fr_exp[2] = 8'd32;
    fr_mv[5]  = 64'd0;
    fr_exp[5] = 8'd0;
    fr_err    = 1'b0;
    send_frame(t_last);
    recv_frame(16, 3, t_last, 1'b0);

    // Reset while element 7 is in the divider, then a clean frame.
    build_vec(tbl[0]);
    send_frame(t_last);
    recv_frame(7, -1, t_last, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_abort_in_ready", bus.in_ready, 1);
    repeat (20) @(negedge clk);
    chk("post_abort_no_valid", bus.out_valid, 0);
    chk("post_abort_no_lut", bus.lut_req, 0);
    build_vec(tbl[4]);
    lut_base = lut_cnt;
    send_frame(t_last);
    recv_frame(16, -1, t_last, 1'b1);
    chk("lut_reads_fresh", lut_cnt - lut_base, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/star_softmax_norm.md
Name: star_softmax_norm

Overview:
- Normalisation stage directly downstream of the STAR match-vector engine.
- Consumes one row per frame: 16 one-hot subtraction match vectors (bucket of xmax−xi) plus the per-bucket occupancy histogram.
- Builds the softmax denominator from the exp LUT, then emits one fixed-point probability per element via a sequential restoring divider.

Parameters:
- N_ELEM, 16: elements per row (beats per frame).
- N_BKT, 64: match-vector width / number of exp buckets.
- CNT_W, 5: histogram count width per bucket.
- EXP_W, 8: exp LUT data width.
- DEN_W, 12: denominator accumulator width (holds N_ELEM·(2^EXP_W−1)).
- OUT_W, 8: output fraction bits (result = exp·2^OUT_W / denom).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- in_sub_mv  in  N_BKT  one-hot bucket vector for current element.
- in_sum_mv  in  N_BKT·CNT_W  packed histogram; bucket k at bits [k·CNT_W +: CNT_W].
- lut_req  out  1  exp LUT read strobe.
- lut_addr  out  6  exp LUT address (bucket index).
- lut_data  in  EXP_W  LUT read data, valid the cycle after lut_req.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  normalised probability.
- out_idx  out  4  element index 0..N_ELEM−1.
- out_last  out  1  marks element N_ELEM−1.
- err_zero_den  out  1  sticky for the frame: denominator was 0.
- done  out  1  one-cycle pulse after last result accepted.

Behaviour:
- Reset: all outputs 0 (in_ready 0 while reset asserted), state IDLE, counters/denominator/bucket store cleared. Asserting reset mid-frame aborts immediately. After release the block starts in IDLE with no partial data.
- States: IDLE → COLLECT → ACCUM → LREAD → LWAIT → DIV → OUT → (LREAD | IDLE).
- IDLE: in_ready=1. A beat transfers on in_valid&in_ready.
  - The first beat latches in_sum_mv.
  - err_zero_den clears.
  - Go to COLLECT.
- COLLECT: in_ready=1.
  - Each accepted beat stores bucket = index of lowest set bit of in_sub_mv. Multi-hot uses the lowest bit. An all-zero vector stores a "null" flag, and that element's numerator is 0.
  - After beat N_ELEM−1, in_ready drops the next cycle. Go to ACCUM.
- ACCUM: 64 LUT reads, addr 0..63, one per cycle, lut_req=1.
  - denom += count[k]·lut_data on the cycle data returns.
  - 65 cycles total, then LREAD with element 0.
  - Arithmetic is unsigned. The multiply is CNT_W×EXP_W. Accumulation wraps in DEN_W bits; wrap is not flagged.
- LREAD: lut_req=1, lut_addr=bucket[j].
- LWAIT: numerator = lut_data (0 if null).
  - If denom==0, set err_zero_den, force the result to 0, and go directly to OUT.
- DIV: OUT_W+1-step restoring division of numerator·2^OUT_W by denom, one quotient bit per cycle.
  - Quotient ≥ 2^OUT_W saturates to 2^OUT_W−1.
- OUT: out_valid=1. out_data, out_idx, out_last are held stable until out_ready.
  - On handshake: if j==N_ELEM−1, pulse done and go to IDLE; else j+1 → LREAD.
- Latency: first out_valid asserts 65 + 3 + (OUT_W+1) cycles after the last input beat. Each subsequent result takes OUT_W+4 cycles after the previous handshake (when out_ready is held high).
- lut_req=0 and in_ready=0 in all states not listed above.
- out_ready has no effect outside OUT.
- in_valid is ignored when in_ready=0.

Test Plan:
- All 16 vectors bit0, count[0]=16, lut[0]=255, other LUT entries 0 → denom 4080, 16 results out_data=16, idx 0..15, out_last on idx 15, done one cycle after the last handshake.
- Element0 bit0 (lut 255, count 1); elements1-15 bit63 (lut[63]=0, count 15) → denom 255, idx0 out_data=255 (saturated from 256), all others 0.
- All LUT entries 0 → err_zero_den=1, all 16 out_data=0, done still pulses.
- Hold out_ready=0 for 10 cycles during OUT for idx 3 → out_valid stays high; out_data/out_idx stay stable; no LUT activity; idx 4 follows the release.
- in_sub_mv=0x0000_0000_0000_0006 for element 2 → treated as bucket 1; all-zero vector for element 5 → out_data 0 for idx 5.
- Drive reset low during DIV of element 7 → all outputs 0 immediately. After release, in_ready=1 in IDLE. A fresh frame completes correctly with no stale results.
